// File: rtl/key_counter_pkg.sv
// rtl/key_counter_pkg.sv - shared defaults and width helpers for the key event counter
package key_counter_pkg;

    localparam int DEF_N_KEYS          = 4;
    localparam int DEF_CNT_W           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SATURATE        = 0;
    localparam int DEF_REPEAT_DELAY    = 1000;
    localparam int DEF_REPEAT_PERIOD   = 250;

    localparam int DEF_CNT_MAX = (1 << DEF_CNT_W) - 1;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int ctr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/key_event_counter_if.sv
// rtl/key_event_counter_if.sv - key inputs and per-key event/count outputs (master = consumer, slave = counter)
interface key_event_counter_if
    import key_counter_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS,
    parameter int CNT_W  = DEF_CNT_W
);

    logic [N_KEYS-1:0]       key_state;
    logic [N_KEYS-1:0]       clear;
    logic [N_KEYS-1:0]       key_stable;
    logic [N_KEYS-1:0]       press_pulse;
    logic [N_KEYS-1:0]       release_pulse;
    logic [N_KEYS*CNT_W-1:0] count;
    logic [N_KEYS-1:0]       overflow;

    modport master (
        output key_state, clear,
        input  key_stable, press_pulse, release_pulse, count, overflow
    );

    modport slave (
        input  key_state, clear,
        output key_stable, press_pulse, release_pulse, count, overflow
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: two-flop sync, debounce, edge detect
module key_debounce
    import key_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int             DW      = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] db_cnt;
    logic          accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept on the sample that would bring the count to DEBOUNCE_CYCLES.
    assign accept = (sync_b != stable) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync_b == stable) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            stable <= ~stable;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Combinational strobes, valid in the cycle before stable flips.
    assign rise = accept & ~stable;
    assign fall = accept &  stable;

endmodule

// File: rtl/key_event_counter.sv
// rtl/key_event_counter.sv - per-key debounce, press/release strobes and press counters; KEY_EVENT_COUNTER_AUTOREPEAT_EN adds auto-repeat
module key_event_counter
    import key_counter_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SATURATE        = DEF_SATURATE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic                clk,
    input logic                reset,
    key_event_counter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic             stable_q;
        logic             rise;
        logic             fall;
        logic             fire;
        logic             press_q;
        logic             release_q;
        logic             ovf_q;
        logic [CNT_W-1:0] cnt_q;

        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.key_state[i]),
            .stable(stable_q),
            .rise  (rise),
            .fall  (fall)
        );

`ifdef KEY_EVENT_COUNTER_AUTOREPEAT_EN
        localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW       = ctr_width(RPT_SPAN);

        logic [RW-1:0] rpt_cnt;
        logic          rpt_armed;
        logic          rpt_hit;

        // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
        assign rpt_hit = stable_q && !fall &&
                         (rpt_cnt == (rpt_armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (!stable_q || fall) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_cnt + 1'b1;
            end
        end

        assign fire = rise | rpt_hit;
`else
        assign fire = rise;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= fire;
                release_q <= fall;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (bus.clear[i]) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (fire) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                    if (SATURATE == 0) begin
                        cnt_q <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign bus.key_stable[i]               = stable_q;
        assign bus.press_pulse[i]              = press_q;
        assign bus.release_pulse[i]            = release_q;
        assign bus.overflow[i]                 = ovf_q;
        assign bus.count[i*CNT_W +: CNT_W]     = cnt_q;
    end

endmodule

// File: doc/key_event_counter.md
Name: key_event_counter

Overview:
- Parametrised successor to the keyboard press counter; one instance serves the whole synth keyboard.
- Per key, in order:
  - synchronises the raw button level;
  - debounces it;
  - detects press and release edges;
  - keeps a press counter with selectable wrap or saturate behaviour.
- Sits between the raw key pins and the note/voice logic. Exposes debounced key levels, single-cycle press/release strobes and per-key counts.

Parameters:
- N_KEYS, 4, number of key channels (1..32).
- CNT_W, 4, width of each per-key press counter (2..16).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a new level (1..2^20).
- SATURATE, 0, 0 = counter wraps to 0 after max; 1 = counter holds at 2^CNT_W-1.
- REPEAT_DELAY, 1000, cycles a key must stay held before the first auto-repeat (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 250, cycles between subsequent auto-repeats (used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (assert low clears everything; release is synchronous to clk externally).
- key_state  in  N_KEYS  raw, asynchronous button levels, 1 = pressed.
- clear  in  N_KEYS  per-key synchronous clear of count and overflow.
- key_stable  out  N_KEYS  debounced key level.
- press_pulse  out  N_KEYS  one-cycle strobe per accepted press (and per auto-repeat).
- release_pulse  out  N_KEYS  one-cycle strobe per accepted release.
- count  out  N_KEYS*CNT_W  packed counters; key i occupies bits [i*CNT_W +: CNT_W].
- overflow  out  N_KEYS  sticky flag: counter wrapped (SATURATE=0) or increment was blocked at max (SATURATE=1).

Behaviour:
- Reset (reset low): all outputs 0; sync flops, debounce counters and repeat timers 0. Asynchronous assert. A key held through reset release produces a press after normal latency.
- Sync: two flops per key; no logic between them.
- Debounce, per key:
  - Counter clears whenever the synchronised sample equals key_stable.
  - Otherwise it increments.
  - When it would reach DEBOUNCE_CYCLES, key_stable toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes key_stable.
- Latency: count edge 1 as the first edge at which key_state holds the new level. key_stable, press_pulse/release_pulse and the count update all take effect on edge DEBOUNCE_CYCLES+2. With the default 4, that is edge 6.
- press_pulse/release_pulse: high for exactly one cycle; never both in the same cycle for one key.
- Counter, on press_pulse:
  - Below max: count+1.
  - At max, SATURATE=0: count becomes 0 and overflow sets.
  - At max, SATURATE=1: count holds and overflow sets.
- clear[i] high: count[i] and overflow[i] become 0 next edge. clear beats a simultaneous increment: result is 0, not 1. clear does not affect debounce, key_stable or pulses.
- Channels fully independent; simultaneous events on all keys are all handled in the same cycle.
- No handshake: strobes are fire-and-forget; consumers sample on the strobe cycle.

Optional Feature:
- Macro KEY_EVENT_COUNTER_AUTOREPEAT_EN.
- Defined:
  - Per-key repeat timer runs while key_stable=1.
  - First extra press_pulse + increment occurs REPEAT_DELAY cycles after the accepted press edge.
  - Then one every REPEAT_PERIOD cycles while held.
  - Timer clears on release or reset.
  - Repeats obey the same saturate/wrap/clear rules.
- Undefined: no repeat logic synthesised; REPEAT_* ignored; one press_pulse per debounced rising edge only.

Decomposition:
- Package key_counter_pkg:
  - default parameter values;
  - a clog2-based width function for the debounce and repeat counters;
  - a localparam CNT_MAX helper.
- Sub-module key_debounce: one channel of sync, debounce and edge detect.
  - Inputs: clk, reset, raw.
  - Outputs: stable, rise, fall.
- Top level: generate loop of key_debounce, plus counter/overflow/repeat logic per channel.

Test Plan:
- Reset then hold key_state=4'b0001 steady: key_stable[0] and press_pulse[0] rise on edge 6; count[0]=1; other counts stay 0.
- 3-cycle glitch on key 2 (DEBOUNCE_CYCLES=4): no key_stable change, no pulses, count2=0.
- 16 presses on key 1, CNT_W=4, SATURATE=0: count goes 15 -> 0, overflow[1]=1. Repeat with SATURATE=1: holds 15, overflow[1]=1.
- clear[3] asserted on the same cycle as press_pulse[3] with count3=7: next cycle count3=0, overflow[3]=0. A later press gives 1.
- All four keys pressed together: four press_pulses on the same cycle, each count +1. Release all: four release_pulses on edge 6 after release.
- reset driven low mid-debounce with key 0 held: outputs clear immediately. After release, press is accepted edge 6 later, count[0]=1. With AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, held key: pulses at 0, +10, +15, +20 cycles from the press.
